zbt_bank_arbiter: RTL and testbench

// Shares one ZBT SRAM bank between the display reader and two pixel writers (capture

---
 rtl/zbt_bank_arbiter.sv | 134 +++++++++++++
 tb/tb_zbt_bank_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_bank_arbiter.sv
// Arbitrates one ZBT bank between a display reader and two pixel writers, one access per cycle.
// Starved writers win first, then the reader, then the writers in round-robin order.
module zbt_bank_arbiter #(
    parameter int AW       = 19,
    parameter int DW       = 36,
    parameter int LAT      = 2,
    parameter int MAX_WAIT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          wr0_req,
    input  logic [AW-1:0] wr0_addr,
    input  logic [DW-1:0] wr0_data,
    output logic          wr0_ack,
    input  logic          wr1_req,
    input  logic [AW-1:0] wr1_addr,
    input  logic [DW-1:0] wr1_data,
    output logic          wr1_ack,
    output logic [AW-1:0] zbt_addr,
    output logic          zbt_we,
    output logic [DW-1:0] zbt_wdata,
    input  logic [DW-1:0] zbt_rdata,
    output logic          starve_evt
);

    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);

    typedef enum logic [1:0] {GNT_NONE, GNT_RD, GNT_WR0, GNT_WR1} gnt_e;

    gnt_e                   gnt;
    logic                   starved0, starved1, starve_hit, wr_gnt;
    logic [AW-1:0]          sel_addr;
    logic [DW-1:0]          sel_data;
    logic                   rr_q;
    logic [CW-1:0]          wait0_q, wait0_d, wait1_q, wait1_d;
    logic                   starve_q;
    logic [AW-1:0]          addr_q;
    logic                   we_q;
    logic [LAT-1:0]         wv_q;
    logic [LAT-1:0][DW-1:0] wd_q;
    logic [DW-1:0]          wdata_q;
    logic [LAT:0]           rv_q;
    logic                   rvalid_q;
    logic [DW-1:0]          rdata_q;

    always_comb begin
        starved0 = wr0_req && (wait0_q == WAIT_SAT);
        starved1 = wr1_req && (wait1_q == WAIT_SAT);
        gnt      = GNT_NONE;
        if (reset)                    gnt = GNT_NONE;
        else if (starved0 && starved1) gnt = rr_q ? GNT_WR1 : GNT_WR0;
        else if (starved0)             gnt = GNT_WR0;
        else if (starved1)             gnt = GNT_WR1;
        else if (rd_req)               gnt = GNT_RD;
        else if (wr0_req && wr1_req)   gnt = rr_q ? GNT_WR1 : GNT_WR0;
        else if (wr0_req)              gnt = GNT_WR0;
        else if (wr1_req)              gnt = GNT_WR1;
        // Any starved writer outranks the reader, so a starved grant with rd_req high is a preemption.
        starve_hit = !reset && rd_req && (starved0 || starved1);
        wr_gnt     = (gnt == GNT_WR0) || (gnt == GNT_WR1);
        sel_addr   = rd_addr;
        sel_data   = wr0_data;
        case (gnt)
            GNT_WR0: sel_addr = wr0_addr;
            GNT_WR1: begin
                sel_addr = wr1_addr;
                sel_data = wr1_data;
            end
            default: ;
        endcase
    end

    assign rd_ack  = (gnt == GNT_RD);
    assign wr0_ack = (gnt == GNT_WR0);
    assign wr1_ack = (gnt == GNT_WR1);

    always_comb begin
        wait0_d = '0;
        wait1_d = '0;
        if (wr0_req && !wr0_ack) wait0_d = (wait0_q == WAIT_SAT) ? wait0_q : wait0_q + CW'(1);
        if (wr1_req && !wr1_ack) wait1_d = (wait1_q == WAIT_SAT) ? wait1_q : wait1_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q     <= 1'b0;
            wait0_q  <= '0;
            wait1_q  <= '0;
            starve_q <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wv_q     <= '0;
            wd_q     <= '0;
            wdata_q  <= '0;
            rv_q     <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (gnt == GNT_WR0)      rr_q <= 1'b1;
            else if (gnt == GNT_WR1) rr_q <= 1'b0;
            wait0_q  <= wait0_d;
            wait1_q  <= wait1_d;
            starve_q <= starve_q | starve_hit;
            we_q     <= wr_gnt;
            if (gnt != GNT_NONE) addr_q <= sel_addr;
            // Write data trails its address by LAT cycles; the output keeps the last word driven.
            wv_q[0] <= wr_gnt;
            wd_q[0] <= sel_data;
            for (int i = 1; i < LAT; i++) begin
                wv_q[i] <= wv_q[i-1];
                wd_q[i] <= wd_q[i-1];
            end
            if (wv_q[LAT-1]) wdata_q <= wd_q[LAT-1];
            rv_q[0] <= (gnt == GNT_RD);
            for (int i = 1; i <= LAT; i++) rv_q[i] <= rv_q[i-1];
            rvalid_q <= rv_q[LAT];
            if (rv_q[LAT]) rdata_q <= zbt_rdata;
        end
    end

    assign zbt_addr   = addr_q;
    assign zbt_we     = we_q;
    assign zbt_wdata  = wdata_q;
    assign rd_valid   = rvalid_q;
    assign rd_data    = rdata_q;
    assign starve_evt = starve_q;

endmodule

// File: tb/tb_zbt_bank_arbiter.sv
// Directed bench for zbt_bank_arbiter with a behavioural ZBT bank (LAT=2) on the pins.
module tb_zbt_bank_arbiter;

    localparam int AW = 19;
    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rd_req = 1'b0, wr0_req = 1'b0, wr1_req = 1'b0;
    logic [AW-1:0] rd_addr = '0, wr0_addr = '0, wr1_addr = '0;
    logic [DW-1:0] wr0_data = '0, wr1_data = '0;
    logic          rd_ack, wr0_ack, wr1_ack, rd_valid, zbt_we, starve_evt;
    logic [DW-1:0] rd_data, zbt_wdata;
    logic [DW-1:0] zbt_rdata = '0;
    logic [AW-1:0] zbt_addr;

    int vectors = 0;
    int miscompares = 0;

    zbt_bank_arbiter #(.AW(AW), .DW(DW), .LAT(2), .MAX_WAIT(16)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
        .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ack(wr1_ack),
        .zbt_addr(zbt_addr), .zbt_we(zbt_we), .zbt_wdata(zbt_wdata),
        .zbt_rdata(zbt_rdata), .starve_evt(starve_evt)
    );

    always #5 clk = ~clk;

    // Unwritten locations read back as a pattern derived from the address.
    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return {a[16:0], a} ^ 36'h5A5A5A5A5;
    endfunction

    // SRAM bank: command seen in cycle s gets its data in cycle s+2.
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [AW-1:0] h_addr0 = '0, h_addr1 = '0;
    logic          h_we0 = 1'b0, h_we1 = 1'b0;
    always @(negedge clk) begin
        if (h_we1) mem[h_addr1] = zbt_wdata;
        else zbt_rdata = mem.exists(h_addr1) ? mem[h_addr1] : fill(h_addr1);
        h_addr1 = h_addr0; h_we1 = h_we0;
        h_addr0 = zbt_addr; h_we0 = zbt_we;
    end

    task automatic drive_idle();
        rd_req = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            drive_idle();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({zbt_addr, zbt_we, zbt_wdata, rd_valid, rd_data, starve_evt} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: addr=%h we=%b wdata=%h rv=%b rdata=%h starve=%b required all 0",
                     zbt_addr, zbt_we, zbt_wdata, rd_valid, rd_data, starve_evt);
        end
        rd_req = 1'b1; wr0_req = 1'b1; wr1_req = 1'b1;
        #1;
        vectors++;
        if ({rd_ack, wr0_ack, wr1_ack} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_acks: got %b required 000", {rd_ack, wr0_ack, wr1_ack});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        drive_idle();
    endtask

    task automatic test_read_only();
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            rd_req = (c < 3); rd_addr = 19'h00123 + AW'(c);
            @(negedge clk);
            if (c < 3) begin
                vectors++;
                if (rd_ack !== 1'b1) begin
                    miscompares++;
                    $display("FAIL read_ack c=%0d: got %b required 1", c, rd_ack);
                end
            end
            if (c >= 1 && c <= 3) begin
                vectors++;
                if (zbt_addr !== 19'h00123 + AW'(c - 1) || zbt_we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL read_cmd c=%0d: addr=%h we=%b required %h/0", c, zbt_addr, zbt_we, 19'h00123 + AW'(c - 1));
                end
            end
            vectors++;
            if (rd_valid !== (c >= 4 && c <= 6)) begin
                miscompares++;
                $display("FAIL read_valid c=%0d: got %b", c, rd_valid);
            end else if (c >= 4 && c <= 6 && rd_data !== fill(19'h00123 + AW'(c - 4))) begin
                miscompares++;
                $display("FAIL read_data c=%0d: got %h required %h", c, rd_data, fill(19'h00123 + AW'(c - 4)));
            end
        end
        idle(4);
    endtask

    task automatic test_two_writers();
        logic [DW-1:0] exp_d;
        wr0_addr = 19'h00010; wr0_data = 36'hAAAAAAAAA;
        wr1_addr = 19'h00020; wr1_data = 36'h555555555;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            wr0_req = (c < 3); wr1_req = (c < 3);
            @(negedge clk);
            if (c < 3) begin
                vectors++;
                if (wr0_ack !== (c != 1) || wr1_ack !== (c == 1) || rd_ack !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wr_rr c=%0d: wr0_ack=%b wr1_ack=%b rd_ack=%b", c, wr0_ack, wr1_ack, rd_ack);
                end
            end
            if (c >= 1 && c <= 3) begin
                vectors++;
                if (zbt_we !== 1'b1 || zbt_addr !== ((c == 2) ? 19'h00020 : 19'h00010)) begin
                    miscompares++;
                    $display("FAIL wr_cmd c=%0d: we=%b addr=%h", c, zbt_we, zbt_addr);
                end
            end
            if (c == 4) begin
                vectors++;
                if (zbt_we !== 1'b0 || zbt_addr !== 19'h00010) begin
                    miscompares++;
                    $display("FAIL idle_hold: we=%b addr=%h required 0/00010", zbt_we, zbt_addr);
                end
            end
            if (c >= 3) begin
                exp_d = (c == 4) ? 36'h555555555 : 36'hAAAAAAAAA;
                vectors++;
                if (zbt_wdata !== exp_d) begin
                    miscompares++;
                    $display("FAIL wr_data c=%0d: got %h required %h", c, zbt_wdata, exp_d);
                end
            end
        end
    endtask

    task automatic test_starvation();
        rd_addr = 19'h00200; wr1_addr = 19'h00300; wr1_data = 36'h123456789;
        for (int c = 0; c < 22; c++) begin
            @(posedge clk); #1;
            rd_req = (c < 21); wr1_req = (c <= 16);
            @(negedge clk);
            if (c <= 20) begin
                vectors++;
                if (rd_ack !== (c != 16) || wr1_ack !== (c == 16)) begin
                    miscompares++;
                    $display("FAIL starve_ack c=%0d: rd_ack=%b wr1_ack=%b", c, rd_ack, wr1_ack);
                end
            end
            vectors++;
            if (starve_evt !== (c >= 17)) begin
                miscompares++;
                $display("FAIL starve_evt c=%0d: got %b required %b", c, starve_evt, c >= 17);
            end
            if (c == 17) begin
                vectors++;
                if (zbt_we !== 1'b1 || zbt_addr !== 19'h00300) begin
                    miscompares++;
                    $display("FAIL starve_cmd: we=%b addr=%h required 1/00300", zbt_we, zbt_addr);
                end
            end
            if (c == 19) begin
                vectors++;
                if (zbt_wdata !== 36'h123456789) begin
                    miscompares++;
                    $display("FAIL starve_wdata: got %h required 123456789", zbt_wdata);
                end
            end
        end
        idle(6);
    endtask

    task automatic test_mixed();
        rd_addr = 19'h7FFFF; wr0_addr = 19'h00040; wr0_data = 36'hFEDCBA987;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            rd_req = (c < 2); wr0_req = (c <= 2);
            @(negedge clk);
            if (c <= 2) begin
                vectors++;
                if (rd_ack !== (c < 2) || wr0_ack !== (c == 2)) begin
                    miscompares++;
                    $display("FAIL mixed_ack c=%0d: rd_ack=%b wr0_ack=%b", c, rd_ack, wr0_ack);
                end
            end
            if (c == 1 || c == 2) begin
                vectors++;
                if (zbt_addr !== 19'h7FFFF || zbt_we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL mixed_addr c=%0d: addr=%h we=%b required 7ffff/0", c, zbt_addr, zbt_we);
                end
            end
            if (c == 3) begin
                vectors++;
                if (zbt_addr !== 19'h00040 || zbt_we !== 1'b1) begin
                    miscompares++;
                    $display("FAIL mixed_wr: addr=%h we=%b required 00040/1", zbt_addr, zbt_we);
                end
            end
            if (c >= 4) begin
                vectors++;
                if (rd_valid !== (c <= 5) || (c <= 5 && rd_data !== fill(19'h7FFFF))) begin
                    miscompares++;
                    $display("FAIL mixed_rd c=%0d: valid=%b data=%h required %h", c, rd_valid, rd_data, fill(19'h7FFFF));
                end
            end
        end
        idle(2);
    endtask

    task automatic test_ordering();
        logic [DW-1:0] exp_d;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            drive_idle();
            case (c)
                0: begin wr0_req = 1'b1; wr0_addr = 19'h00050; wr0_data = 36'h111111111; end
                1: begin rd_req = 1'b1; rd_addr = 19'h00050; end
                2: begin wr1_req = 1'b1; wr1_addr = 19'h00060; wr1_data = 36'h222222222; end
                3: begin rd_req = 1'b1; rd_addr = 19'h00060; end
                4: begin rd_req = 1'b1; rd_addr = 19'h00070; end
                default: ;
            endcase
            @(negedge clk);
            if (c <= 4) begin
                vectors++;
                if (wr0_ack !== (c == 0) || rd_ack !== (c == 1 || c >= 3) || wr1_ack !== (c == 2)) begin
                    miscompares++;
                    $display("FAIL order_ack c=%0d: rd=%b wr0=%b wr1=%b", c, rd_ack, wr0_ack, wr1_ack);
                end
            end
            exp_d = (c == 5) ? 36'h111111111 : (c == 7) ? 36'h222222222 : fill(19'h00070);
            vectors++;
            if (rd_valid !== (c == 5 || c == 7 || c == 8)) begin
                miscompares++;
                $display("FAIL order_valid c=%0d: got %b", c, rd_valid);
            end else if (rd_valid && rd_data !== exp_d) begin
                miscompares++;
                $display("FAIL order_data c=%0d: got %h required %h", c, rd_data, exp_d);
            end
        end
    endtask

    task automatic test_reset_midtraffic();
        @(posedge clk); #1;
        drive_idle(); wr0_req = 1'b1; wr0_addr = 19'h00080; wr0_data = 36'hAAAAAAAAA;
        @(posedge clk); #1;
        drive_idle(); rd_req = 1'b1; rd_addr = 19'h00090;
        @(posedge clk); #1;
        reset = 1'b1; wr0_req = 1'b1; wr1_req = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rd_ack, wr0_ack, wr1_ack, zbt_addr, zbt_we, zbt_wdata, rd_valid, rd_data, starve_evt} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: acks=%b%b%b addr=%h we=%b wdata=%h rv=%b rdata=%h starve=%b",
                     rd_ack, wr0_ack, wr1_ack, zbt_addr, zbt_we, zbt_wdata, rd_valid, rd_data, starve_evt);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        drive_idle();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (rd_valid !== 1'b0 || zbt_wdata !== '0) begin
                miscompares++;
                $display("FAIL midreset_drop c=%0d: rv=%b wdata=%h required 0/0", c, rd_valid, zbt_wdata);
            end
            @(posedge clk); #1;
        end
        wr0_req = 1'b1; wr1_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (wr0_ack !== 1'b1 || wr1_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_rr: wr0_ack=%b wr1_ack=%b required 1/0", wr0_ack, wr1_ack);
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_only();
        test_two_writers();
        test_starvation();
        test_mixed();
        test_ordering();
        test_reset_midtraffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
